// File: rtl/conv_pkg.sv
// Shared types and defaults for the convolver front end.
// Image geometry defaults are also used by the convolver.
package conv_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int IMG_W_DEF = 8;
  localparam int IMG_H_DEF = 8;

  typedef logic [DATA_W_DEF-1:0] pixel_t;

  typedef enum logic {
    FILL,
    STREAM
  } state_t;
endpackage

// File: rtl/conv_line_buffer_if.sv
// Pixel-in / column-out handshake bundle of the line buffer.
// The line buffer takes the slave side.
interface conv_line_buffer_if
  import conv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              col_valid;
  logic              col_ready;
  logic [DATA_W-1:0] col_top;
  logic [DATA_W-1:0] col_mid;
  logic [DATA_W-1:0] col_bot;
  logic              window_valid;
  logic              frame_done;

  modport master (
    output in_valid, in_data, col_ready,
    input  in_ready, col_valid,
    input  col_top, col_mid, col_bot,
    input  window_valid, frame_done
  );

  modport slave (
    input  in_valid, in_data, col_ready,
    output in_ready, col_valid,
    output col_top, col_mid, col_bot,
    output window_valid, frame_done
  );
endinterface

// File: rtl/conv_line_buffer_line_ram.sv
// One image row of pixels: registered write, combinational read.
// Contents are not reset; the fill rows overwrite them before use.
module line_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 8,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/conv_line_buffer.sv
// Raster stream to vertical 3-pixel columns for the 3x3 convolver.
// Two line RAMs hold rows r-2 and r-1; one output register, no skid.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int COL_W = $clog2(IMG_W),
  parameter int ROW_W = $clog2(IMG_H)
) (
  input logic clk,
  input logic reset,
  conv_line_buffer_if.slave bus
);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  state_t            state;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col_c;
  logic              last;
  logic              col_valid;
  logic [DATA_W-1:0] col_top;
  logic [DATA_W-1:0] col_mid;
  logic [DATA_W-1:0] col_bot;
  logic [DATA_W-1:0] l0_q;
  logic [DATA_W-1:0] l1_q;
  logic              accept;
  logic              row_end;
  logic              frame_end;

  assign bus.in_ready = !col_valid || bus.col_ready;
  assign accept = bus.in_valid && bus.in_ready;
  assign row_end = col == COL_LAST;
  assign frame_end = row_end && row == ROW_LAST;

  line_ram #(
    .DATA_W(DATA_W), .DEPTH(IMG_W), .AW(COL_W)
  ) u_line0 (
    .clk, .we(accept), .waddr(col), .wdata(l1_q),
    .raddr(col), .rdata(l0_q)
  );

  line_ram #(
    .DATA_W(DATA_W), .DEPTH(IMG_W), .AW(COL_W)
  ) u_line1 (
    .clk, .we(accept), .waddr(col), .wdata(bus.in_data),
    .raddr(col), .rdata(l1_q)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= FILL;
      col       <= '0;
      row       <= '0;
      col_valid <= 1'b0;
      col_top   <= '0;
      col_mid   <= '0;
      col_bot   <= '0;
      col_c     <= '0;
      last      <= 1'b0;
    end else begin
      if (accept) begin
        if (row_end) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
        unique case (state)
          FILL:
            if (row_end && row == ROW_W'(1)) state <= STREAM;
          STREAM:
            if (frame_end) state <= FILL;
        endcase
      end
      // A column left over from the last pixel drains even in FILL.
      if (accept && state == STREAM) begin
        col_valid <= 1'b1;
        col_top   <= l0_q;
        col_mid   <= l1_q;
        col_bot   <= bus.in_data;
        col_c     <= col;
        last      <= frame_end;
      end else if (col_valid && bus.col_ready) begin
        col_valid <= 1'b0;
      end
    end
  end

  assign bus.col_valid = col_valid;
  assign bus.col_top = col_top;
  assign bus.col_mid = col_mid;
  assign bus.col_bot = col_bot;
  assign bus.window_valid = col_valid && col_c >= COL_W'(2);
  assign bus.frame_done = col_valid && last;
endmodule

// File: doc/conv_line_buffer.md
Name: conv_line_buffer

Overview:
Upstream feeder for the convolver datapath. Accepts a raster-order pixel stream and uses two on-chip line buffers to emit one vertical 3-pixel column per accepted pixel from row 2 onward. The convolver shifts each column into its 3x3 window on its three_shift strobe. The block tracks row/column position, flags when a full 3x3 window exists downstream, and pulses at end of frame.

Parameters:
DATA_W, 8, pixel width in bits
IMG_W, 8, pixels per row (>=3)
IMG_H, 8, rows per frame (>=3)
COL_W, $clog2(IMG_W), column counter width
ROW_W, $clog2(IMG_H), row counter width

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
in_valid  input  1  in_data is valid this cycle
in_ready  output  1  block can accept a pixel this cycle
in_data  input  DATA_W  raster-order pixel
col_valid  output  1  column outputs valid; drives convolver three_shift
col_ready  input  1  downstream accepts the column this cycle
col_top  output  DATA_W  pixel (r-2, c)
col_mid  output  DATA_W  pixel (r-1, c)
col_bot  output  DATA_W  pixel (r, c)
window_valid  output  1  col_valid and c>=2 (full 3x3 window after this shift)
frame_done  output  1  asserted with the column of pixel (IMG_H-1, IMG_W-1)

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (named reset).
- Accept event: in_valid && in_ready. Output handoff: col_valid && col_ready.
- in_ready = !col_valid || col_ready, combinational. Single output register, no skid buffer, zero bubbles under continuous flow.
- Storage: line0[IMG_W] holds row r-2; line1[IMG_W] holds row r-1.
- On accept at column c: line0[c] <= line1[c]; line1[c] <= in_data.
- In STREAM only, the output register also loads col_top=line0[c], col_mid=line1[c], col_bot=in_data, col_c=c, last=(r==IMG_H-1 && c==IMG_W-1).
- Latency: column valid 1 cycle after accept. Output holds stable while col_valid && !col_ready.
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) advance on accept only. col wraps to 0 and increments row. row wraps to 0 after the last pixel.
- FSM:
  - FILL (rows 0-1): accept and store only, col_valid stays 0. Go to STREAM on accepting (1, IMG_W-1).
  - STREAM: each accept produces a column. Go to FILL on accepting (IMG_H-1, IMG_W-1).
- Drop of col_valid: in FILL, col_valid clears on handoff. A pending column from the last pixel remains valid until handed off, even after the FSM returns to FILL.
- Derived outputs: window_valid = col_valid && col_c>=2. frame_done = col_valid && last, so it stays high while held under backpressure.
- Back-to-back frames: the next frame's pixels may be accepted in the same cycle the last column is handed off.
- Reset values: col_valid=0, window_valid=0, frame_done=0, col_top/mid/bot=0, col=0, row=0, state=FILL. in_ready=1 after reset.
- Line RAM contents are not reset. FILL overwrites them before any use.
- Reset mid-frame: the partial frame is discarded and the next accepted pixel is treated as (0,0).
- in_valid low: no state change. in_data is ignored when not accepted.

Decomposition:
- Shared package conv_pkg: DATA_W default, pixel_t typedef, FSM state enum (FILL, STREAM), and IMG_W/IMG_H defaults shared with the convolver.
- One natural sub-module: line_ram, a single-port-read/single-port-write IMG_W x DATA_W array with combinational read, instantiated twice.
- Counters, FSM and output register live in the top.

Test Plan:
- Stimulus: IMG_W=4, IMG_H=4, in_data=16*r+c, continuous valid, col_ready=1. Required: exactly 8 columns; first column (top,mid,bot)=(0x00,0x10,0x20) 1 cycle after accepting pixel 0x20; last column=(0x13,0x23,0x33) with frame_done=1.
- Same stream: window_valid high only for columns c=2,3, i.e. 4 pulses per frame.
- Backpressure: hold col_ready=0 for 3 cycles mid-row. Required: in_ready=0, outputs frozen, no pixel lost; the column sequence matches the no-stall run.
- Random in_valid gaps (50%) over two back-to-back frames with distinct data. Required: the second frame's columns use only second-frame pixels and frame_done pulses twice.
- Assert reset low at pixel (2,1), then restart the frame. Required: col_valid=0 the cycle after reset; the new frame's first column appears only after 2 full rows are refilled.
- Last column stalled (col_ready=0) while new-frame pixel (0,0) is offered. Required: in_ready=0 until handoff, then (0,0) is accepted with no spurious column.
